// File: rtl/serial_101_tx.sv
// ---------------------------------------------------------------------------
// serial_101_tx
//
// Serialises a WIDTH-bit payload word into a framed bit stream for a
// downstream "101" Moore detector.
//
// A frame has three parts:
//   - a fixed 1,0,1 preamble,
//   - the payload, sent MSB first,
//   - an optional even-parity bit.
//
// Between frames there is always at least one idle cycle. In an idle cycle
// dout_valid is 0 and dout is 0.
//
// Optional feature macro: SERIAL_101_PARITY_EN
//   - Undefined (default): the frame is WIDTH+3 bits long. The PAR state and
//     the parity logic are not built.
//   - Defined: a PAR state follows DATA and sends XOR(payload). The frame is
//     then WIDTH+4 bits long.
//
// Parameters
//   WIDTH       payload word width in bits (>= 1)
//
// Ports
//   CLK         single clock, rising-edge active
//   RST         synchronous, active-high reset
//   load        transmit request, accepted only while ready is high
//   data_in     payload word, captured when load is accepted
//   ready       high while idle and able to accept load
//   dout        serial frame bit
//   dout_valid  high in every cycle that dout carries a frame bit
//   done        one-cycle pulse coinciding with the final frame bit
// ---------------------------------------------------------------------------
module serial_101_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  // Bit counter wide enough to hold WIDTH itself. This keeps the count from
  // wrapping inside a frame for any legal WIDTH, including WIDTH=1.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_101_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;

  logic ready_q, ready_d;
  logic dout_q, dout_d;
  logic dout_valid_q, dout_valid_d;
  logic done_q, done_d;

`ifdef SERIAL_101_PARITY_EN
  // Parity is computed once, when the word is captured. The shift register
  // is consumed while the payload is sent, so it cannot be used later.
  logic parity_q, parity_d;
`endif

  // ------------------------------------------------------------------
  // Next-state logic.
  //
  // IDLE is the only state that accepts load. A load arriving while a
  // frame is in progress is therefore dropped, not queued.
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef SERIAL_101_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = PRE;
          pre_cnt_d = 2'd0;
          bit_cnt_d = '0;
          shift_d   = data_in;
`ifdef SERIAL_101_PARITY_EN
          parity_d  = ^data_in;
`endif
        end
      end

      PRE: begin
        if (pre_cnt_q == 2'd2) begin
          state_d   = DATA;
          pre_cnt_d = 2'd0;
        end else begin
          pre_cnt_d = pre_cnt_q + 2'd1;
        end
      end

      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_101_PARITY_EN
          state_d = PAR;
`else
          state_d = IDLE;
`endif
          bit_cnt_d = '0;
        end else begin
          // The shift and the count advance together.
          // After the shift, the next payload bit sits at the MSB.
          bit_cnt_d = bit_cnt_q + CW'(1);
          shift_d   = shift_q << 1;
        end
      end

`ifdef SERIAL_101_PARITY_EN
      PAR: begin
        state_d = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output decode.
  //
  // The outputs are decoded from the state being entered and then
  // registered. The registered outputs therefore always describe the
  // current state, and the first preamble bit appears in the cycle right
  // after the load is accepted.
  // ------------------------------------------------------------------
  always_comb begin
    ready_d      = 1'b0;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;

    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end

      PRE: begin
        // The preamble is 1,0,1. Only the middle position is a zero.
        dout_d       = (pre_cnt_d != 2'd1);
        dout_valid_d = 1'b1;
      end

      DATA: begin
        dout_d       = shift_d[WIDTH-1];
        dout_valid_d = 1'b1;
`ifndef SERIAL_101_PARITY_EN
        done_d       = (bit_cnt_d == LAST_BIT);
`endif
      end

`ifdef SERIAL_101_PARITY_EN
      PAR: begin
        dout_d       = parity_d;
        dout_valid_d = 1'b1;
        done_d       = 1'b1;
      end
`endif

      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State and output registers.
  //
  // Reset has priority over load at the same edge. A reset therefore
  // aborts any frame in progress, and no done pulse is produced for it.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      pre_cnt_q    <= 2'd0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ready_q      <= 1'b1;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_101_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ready_q      <= ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
`ifdef SERIAL_101_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_101_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_101_tx
//
// Self-checking bench for serial_101_tx with WIDTH=8.
//
// Stimulus is a set of directed sequences followed by a randomized run.
//
// Reference model (posedge):
//   - Reset empties the queue of expected bits.
//   - A load seen during an idle cycle pushes the whole expected frame
//     into the queue.
//
// Monitor (negedge):
//   - If a bit is pending, the DUT must present it.
//   - If nothing is pending, the DUT must be idle and ready.
//
// The monitor also runs a behavioural "101" detector on dout.
// ---------------------------------------------------------------------------
module tb_serial_101_tx;

  localparam int WIDTH = 8;

  // Frame length includes the 3-bit preamble, plus one parity bit when
  // SERIAL_101_PARITY_EN is defined.
`ifdef SERIAL_101_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 4;
`else
  localparam int FRAME_LEN = WIDTH + 3;
`endif

  typedef struct packed {
    logic bit_val;
    logic last;
  } exp_bit_t;

  logic             CLK;
  logic             RST;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             done;

  exp_bit_t exp_q[$];
  logic     cur_frame;
  logic     mon_en;
  int       check_cnt;
  int       fail_cnt;
  int       det_cnt;
  logic [2:0] det_hist;

  serial_101_tx #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its expected value.
  // Every call counts as a comparison; a mismatch prints a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's worth of inputs, then advance to just after the
  // next rising edge.
  task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] d,
                               input logic r);
    load    = l;
    data_in = d;
    RST     = r;
    @(posedge CLK);
    #1;
  endtask

  // Reference model at the frame level.
  // A frame is the preamble 1,0,1, then the word MSB first, then (when
  // enabled) the even parity bit. Only the final bit is marked last.
  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else if (load && !cur_frame) begin
      logic [WIDTH-1:0] w;
      exp_bit_t e;
      w = data_in;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (i < 3)
          e.bit_val = (i != 1);
        else if (i < WIDTH + 3)
          e.bit_val = w[WIDTH - 1 - (i - 3)];
        else
          e.bit_val = ^w;
        e.last = (i == FRAME_LEN - 1);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: checks the DUT outputs once per cycle, on the falling edge.
  // It also feeds dout into a "101" detector that counts every match.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        exp_bit_t e;
        e = exp_q.pop_front();
        cur_frame = 1'b1;
        checkOutput("dout_valid", 32'(dout_valid), 32'd1);
        checkOutput("dout", 32'(dout), 32'(e.bit_val));
        checkOutput("done", 32'(done), 32'(e.last));
        checkOutput("ready_busy", 32'(ready), 32'd0);
      end else begin
        cur_frame = 1'b0;
        checkOutput("idle_valid", 32'(dout_valid), 32'd0);
        checkOutput("idle_dout", 32'(dout), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_ready", 32'(ready), 32'd1);
      end
      det_hist = {det_hist[1:0], dout};
      if (det_hist == 3'b101)
        det_cnt++;
    end
  end

  initial begin
    check_cnt = 0;
    fail_cnt  = 0;
    det_cnt   = 0;
    det_hist  = 3'b000;
    cur_frame = 1'b0;
    mon_en    = 1'b0;
    load      = 1'b0;
    data_in   = '0;
    RST       = 1'b1;

    // Reset.
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    mon_en = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);

    // Single frame of 8'hA5.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Frame of 8'h07. In the parity build this frame has a parity bit.
    applyStimulus(1'b1, 8'h07, 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    // 8'hFF accepted; a load of 8'h00 pulsed mid-frame must be ignored.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset at cycle 6 of a frame, then a clean 8'h3C frame.
    applyStimulus(1'b1, 8'h99, 1'b0);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset and load at the same edge: reset wins and the load is dropped.
    applyStimulus(1'b1, 8'h5A, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Load held high for 30 cycles with varying data.
    // Frames must run back-to-back with exactly one idle cycle between them.
    for (int i = 0; i < 30; i++)
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Loopback: three 8'h00 frames must give exactly one detection each.
    det_cnt = 0;
    for (int i = 0; i < 3 * (FRAME_LEN + 1); i++)
      applyStimulus(1'b1, 8'h00, 1'b0);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("loopback_detect", 32'(det_cnt), 32'd3);

    // Randomized run with occasional resets.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 99) < 40, WIDTH'($urandom),
                    $urandom_range(0, 99) < 3);
    repeat (FRAME_LEN + 3) applyStimulus(1'b0, 8'h00, 1'b0);

    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/serial_101_tx.md
SERIAL_101_TX -- requirements
Module: serial_101_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the payload word width in bits; legal values are WIDTH >= 1.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port load  input  1  request to transmit data_in, sampled on the CLK rising edge.
REQ-005 The block SHALL have port data_in  input  WIDTH  payload word, captured when load is accepted.
REQ-006 The block SHALL have port ready  output  1  high when the block can accept load.
REQ-007 The block SHALL have port dout  output  1  serial bit stream feeding the downstream "101" Moore detector.
REQ-008 The block SHALL have port dout_valid  output  1  high in every cycle in which dout carries a frame bit.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, PRE, DATA and (with REQ-024) PAR; all outputs SHALL be registered and SHALL depend on state only.
REQ-011 In IDLE the block SHALL drive ready=1, dout=0, dout_valid=0 and done=0.
REQ-012 A load SHALL be accepted only at a rising edge where ready=1 and load=1; data_in SHALL be captured into an internal WIDTH-bit shift register at that edge.
REQ-013 A load asserted while ready=0 SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-014 On acceptance the FSM SHALL enter PRE and drive the preamble 1, 0, 1 on dout over 3 consecutive cycles, with dout_valid=1 and ready=0.
REQ-015 After the preamble the FSM SHALL enter DATA and drive the captured word MSB first over WIDTH consecutive cycles, with dout_valid=1.
REQ-016 A 2-bit counter SHALL track the preamble position, and a counter of width ceil(log2(WIDTH+1)) SHALL track the data bit position; neither counter SHALL wrap within a frame.
REQ-017 The block SHALL assert done=1 in the cycle that drives the final frame bit (last DATA bit, or the PAR bit when REQ-024 applies); done SHALL be 0 in all other cycles.
REQ-018 In the cycle after the final bit the FSM SHALL be in IDLE with ready=1, giving at least one idle cycle (dout_valid=0) between consecutive frames.
REQ-019 With load held high continuously, frames SHALL repeat back-to-back, separated by exactly one idle cycle.
REQ-020 Payload bits SHALL NOT be escaped or stuffed; a "101" pattern inside the payload is transmitted unchanged.

Reset
REQ-021 RST=1 at a rising edge SHALL force IDLE, clear the shift register and counters, and drive ready=1, dout=0, dout_valid=0 and done=0 from the following cycle.
REQ-022 RST asserted mid-frame SHALL abort the frame and discard the remaining bits, with no done pulse.
REQ-023 If RST and load are both high at the same edge, RST SHALL win and the load SHALL be dropped.

Configuration
REQ-024 With macro SERIAL_101_PARITY_EN defined, the FSM SHALL enter PAR after DATA and drive one even-parity bit (XOR of all WIDTH payload bits) with dout_valid=1, giving a frame length of WIDTH+4.
REQ-025 Without SERIAL_101_PARITY_EN, the PAR state and the parity logic SHALL be absent, and the frame length SHALL be WIDTH+3.

Verification
REQ-026 WIDTH=8, no parity: load 8'hA5 at cycle 0 -> cycles 1..11 give dout 1,0,1,1,0,1,0,0,1,0,1 with dout_valid=1; done=1 at cycle 11 only; ready=1 at cycle 12.
REQ-027 WIDTH=8 with SERIAL_101_PARITY_EN: load 8'h07 -> 11 bits as per REQ-026 pattern (1,0,1,0,0,0,0,0,1,1,1), then parity bit 1 at cycle 12 with done=1; ready=1 at cycle 13.
REQ-028 Load 8'hFF accepted, then load 8'h00 pulsed at cycle 5 -> 8'h00 ignored; the frame completes with payload 8'hFF.
REQ-029 RST pulsed at cycle 6 of a frame -> from cycle 7: dout=0, dout_valid=0, ready=1; no done pulse; a new load of 8'h3C afterwards produces a correct full frame.
REQ-030 Load held at 1 for 30 cycles, WIDTH=8, no parity -> frames start at cycles 1, 13 and 25, each preceded by exactly one dout_valid=0 cycle.
REQ-031 Loopback: dout fed into the "101" Moore detector with load 8'h00 -> detector output Y pulses exactly once per frame, on the preamble.
